// File: rtl/circle_job_arbiter.sv
// Round-robin front end that shares one circle_lines generator between NUM_REQ clients.
// Launches one job at a time, forwards tagged pixels and reports completion/error per job.
module circle_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  _clock,
  input  logic                  _reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_x,
  input  logic [NUM_REQ*32-1:0] req_y,
  input  logic [NUM_REQ*32-1:0] req_r,
  output logic                  gen_start,
  output logic [31:0]           gen_s_x,
  output logic [31:0]           gen_s_y,
  output logic [31:0]           gen_height,
  input  logic [31:0]           gen_out0,
  input  logic [31:0]           gen_out1,
  input  logic                  gen_valid,
  input  logic                  gen_done,
  output logic                  pix_valid,
  output logic [31:0]           pix_x,
  output logic [31:0]           pix_y,
  output logic [ID_W-1:0]       pix_id,
  output logic                  job_done,
  output logic [ID_W-1:0]       job_id,
  output logic                  job_err,
  output logic [31:0]           job_pix_count
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] rr_reg;
  logic [ID_W-1:0] id_reg;
  logic            err_reg;
  logic [31:0]     pix_cnt_reg;
  logic [31:0]     cyc_reg;

  logic [31:0]     x_arr [NUM_REQ];
  logic [31:0]     y_arr [NUM_REQ];
  logic [31:0]     r_arr [NUM_REQ];

  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] grant_id;
  logic            grant_found;
  logic            handshake;
  logic            timeout_hit;
  logic [31:0]     sel_r;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign x_arr[gi] = req_x[32*gi +: 32];
    assign y_arr[gi] = req_y[32*gi +: 32];
    assign r_arr[gi] = req_r[32*gi +: 32];
  end

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_reg) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign handshake   = (state_reg == IDLE) && grant_found;
  assign sel_r       = r_arr[grant_id];
  assign timeout_hit = (cyc_reg >= 32'(TIMEOUT_CYCLES - 1));

  // Ready is suppressed during reset so no client sees a grant that cannot complete.
  assign req_ready = (handshake && !_reset) ? (NUM_REQ'(1) << grant_id) : '0;

  assign gen_start     = (state_reg != RUN);
  assign job_done      = (state_reg == DONE);
  assign job_id        = id_reg;
  assign job_err       = err_reg;
  assign job_pix_count = pix_cnt_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = sel_r[31] ? DONE : LAUNCH;
      LAUNCH:  state_next = RUN;
      RUN:     if (gen_done || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_reg   <= IDLE;
      rr_reg      <= ID_W'(NUM_REQ - 1);
      id_reg      <= '0;
      err_reg     <= 1'b0;
      pix_cnt_reg <= '0;
      cyc_reg     <= '0;
      gen_s_x     <= '0;
      gen_s_y     <= '0;
      gen_height  <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_id      <= '0;
    end else begin
      state_reg <= state_next;
      pix_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            rr_reg      <= grant_id;
            id_reg      <= grant_id;
            err_reg     <= sel_r[31];
            pix_cnt_reg <= '0;
            // Rejected jobs leave the generator operands untouched.
            if (!sel_r[31]) begin
              gen_s_x    <= x_arr[grant_id];
              gen_s_y    <= y_arr[grant_id];
              gen_height <= sel_r;
            end
          end
        end
        LAUNCH: cyc_reg <= '0;
        RUN: begin
          if (cyc_reg != '1) cyc_reg <= cyc_reg + 32'd1;
          if (gen_valid) begin
            pix_valid <= 1'b1;
            pix_x     <= gen_out0;
            pix_y     <= gen_out1;
            pix_id    <= id_reg;
            if (pix_cnt_reg != '1) pix_cnt_reg <= pix_cnt_reg + 32'd1;
          end
          if (!gen_done && timeout_hit) err_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_job_arbiter.sv
// Directed and randomized jobs against a transaction-level model of the arbiter:
// expected winner, operands, pixel stream (with arrival cycle) and completion record.
module tb_circle_job_arbiter;
  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*32-1:0] req_x = '0, req_y = '0, req_r = '0;
  logic            gen_start;
  logic [31:0]     gen_s_x, gen_s_y, gen_height;
  logic [31:0]     gen_out0 = '0, gen_out1 = '0;
  logic            gen_valid = 1'b0, gen_done = 1'b0;
  logic            pix_valid;
  logic [31:0]     pix_x, pix_y;
  logic [1:0]      pix_id;
  logic            job_done;
  logic [1:0]      job_id;
  logic            job_err;
  logic [31:0]     job_pix_count;

  circle_job_arbiter #(.NUM_REQ(NR), .ID_W(2), .TIMEOUT_CYCLES(TO)) dut (
    ._clock(clk), ._reset(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_r(req_r),
    .gen_start(gen_start), .gen_s_x(gen_s_x), .gen_s_y(gen_s_y), .gen_height(gen_height),
    .gen_out0(gen_out0), .gen_out1(gen_out1), .gen_valid(gen_valid), .gen_done(gen_done),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_id(pix_id),
    .job_done(job_done), .job_id(job_id), .job_err(job_err), .job_pix_count(job_pix_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] t;
  } pix_t;

  int unsigned tick = 0;
  pix_t exp_q[$];
  pix_t obs_q[$];
  int checks = 0;
  int failures = 0;
  int last_g = NR - 1;
  logic [31:0] rx [NR];
  logic [31:0] ry [NR];
  logic [31:0] rad [NR];

  always @(posedge clk) tick++;

  always @(posedge clk) begin
    #1;
    if (pix_valid === 1'b1) obs_q.push_back('{id: pix_id, x: pix_x, y: pix_y, t: 32'(tick)});
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Winner is the first valid requester after the previous winner, cyclically.
  function automatic int pick(input logic [NR-1:0] m, input int last);
    for (int k = 1; k <= NR; k++)
      if (m[(last + k) % NR]) return (last + k) % NR;
    return 0;
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < NR; i++) begin
      req_x[32*i +: 32] = rx[i];
      req_y[32*i +: 32] = ry[i];
      req_r[32*i +: 32] = rad[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      rx[i]  = $urandom;
      ry[i]  = $urandom;
      rad[i] = ($urandom_range(3, 0) == 0) ? -32'($urandom_range(100, 1)) : 32'($urandom_range(200, 0));
    end
  endtask

  task automatic compare_pixels(input string name);
    check({name, ":pix_n"}, 128'(obs_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({name, ":pix"}, 128'(obs_q[i]), 128'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_job(input logic [NR-1:0] mask, input bit hold, input bit stale,
                        input int run_len, input bit hang, input string name);
    int g, cnt, len;
    logic [NR-1:0] oh;
    logic [31:0] ex, ey, er;
    @(negedge clk);
    pack_ops();
    req_valid = mask;
    g = pick(mask, last_g);
    oh = NR'(1) << g;
    #1;
    check({name, ":ready"}, 128'(req_ready), 128'(oh));
    ex = rx[g]; ey = ry[g]; er = rad[g];
    last_g = g;
    @(negedge clk);
    if (!hold) req_valid = '0;
    if (er[31]) begin
      check({name, ":neg_done"}, 128'(job_done), 128'(1));
      check({name, ":neg_id"}, 128'(job_id), 128'(g));
      check({name, ":neg_err"}, 128'(job_err), 128'(1));
      check({name, ":neg_cnt"}, 128'(job_pix_count), 128'(0));
      check({name, ":neg_start"}, 128'(gen_start), 128'(1));
      check({name, ":neg_ready"}, 128'(req_ready), 128'(0));
      compare_pixels(name);
      $display("job %s id=%0d r=%0d err=1 count=0", name, g, $signed(er));
      return;
    end
    check({name, ":launch_start"}, 128'(gen_start), 128'(1));
    check({name, ":launch_sx"}, 128'(gen_s_x), 128'(ex));
    check({name, ":launch_sy"}, 128'(gen_s_y), 128'(ey));
    check({name, ":launch_h"}, 128'(gen_height), 128'(er));
    check({name, ":launch_ready"}, 128'(req_ready), 128'(0));
    gen_done = stale;
    len = hang ? TO : run_len;
    cnt = 0;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      gen_done = 1'b0;
      gen_valid = 1'b0;
      check({name, ":run_start"}, 128'(gen_start), 128'(0));
      check({name, ":run_done"}, 128'(job_done), 128'(0));
      check({name, ":run_ready"}, 128'(req_ready), 128'(0));
      if ($urandom_range(1, 0) == 1) begin
        gen_valid = 1'b1;
        gen_out0 = $urandom;
        gen_out1 = $urandom;
        exp_q.push_back('{id: g[1:0], x: gen_out0, y: gen_out1, t: 32'(tick + 1)});
        cnt++;
      end
      if (!hang && c == len) gen_done = 1'b1;
    end
    @(negedge clk);
    gen_valid = 1'b0;
    gen_done = 1'b0;
    check({name, ":done"}, 128'(job_done), 128'(1));
    check({name, ":done_id"}, 128'(job_id), 128'(g));
    check({name, ":done_err"}, 128'(job_err), 128'(hang));
    check({name, ":done_cnt"}, 128'(job_pix_count), 128'(cnt));
    check({name, ":done_start"}, 128'(gen_start), 128'(1));
    check({name, ":done_ready"}, 128'(req_ready), 128'(0));
    compare_pixels(name);
    $display("job %s id=%0d x=%0d y=%0d r=%0d err=%0d count=%0d", name, g,
             $signed(ex), $signed(ey), $signed(er), hang, cnt);
  endtask

  initial begin
    int g;
    // Reset: outputs idle and ready held low even with every request pending.
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    check("rst:ready", 128'(req_ready), 128'(0));
    check("rst:start", 128'(gen_start), 128'(1));
    check("rst:done", 128'(job_done), 128'(0));
    check("rst:pix_valid", 128'(pix_valid), 128'(0));
    check("rst:sx", 128'(gen_s_x), 128'(0));
    check("rst:cnt", 128'(job_pix_count), 128'(0));
    req_valid = '0;
    rst = 1'b0;

    // All requesters valid continuously: five back-to-back jobs.
    rand_ops();
    for (int i = 0; i < NR; i++) rad[i] = 32'($urandom_range(50, 0));
    for (int j = 0; j < 5; j++) do_job(4'hF, 1'b1, 1'b0, $urandom_range(8, 1), 1'b0, "rr");
    req_valid = '0;

    // Single requester 0 with a small circle.
    rx[0] = 32'd10; ry[0] = 32'd20; rad[0] = 32'd3;
    do_job(4'b0001, 1'b0, 1'b0, 7, 1'b0, "single");

    // Negative radius on requester 2.
    rad[2] = -32'sd1;
    do_job(4'b0100, 1'b0, 1'b0, 1, 1'b0, "negr");

    // Generator never finishes.
    rand_ops(); rad[1] = 32'd9;
    do_job(4'b0010, 1'b0, 1'b0, 0, 1'b1, "timeout");

    // Stale done from the previous job visible during LAUNCH.
    rand_ops(); rad[3] = 32'd4;
    do_job(4'b1000, 1'b0, 1'b1, 6, 1'b0, "stale");

    for (int j = 0; j < 10; j++) begin
      rand_ops();
      do_job(4'($urandom_range(15, 1)), 1'b0, 1'($urandom_range(1, 0)),
             $urandom_range(12, 1), ($urandom_range(5, 0) == 0), "rand");
    end

    // Reset in the middle of a RUN, with a pixel strobe in the reset cycle.
    rand_ops(); rad[1] = 32'd5;
    @(negedge clk);
    pack_ops();
    req_valid = 4'b0010;
    g = pick(req_valid, last_g);
    #1;
    check("midrst:ready", 128'(req_ready), 128'(NR'(1) << g));
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("midrst:run_start", 128'(gen_start), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    gen_valid = 1'b1;
    gen_out0 = $urandom;
    @(negedge clk);
    check("midrst:start", 128'(gen_start), 128'(1));
    check("midrst:done", 128'(job_done), 128'(0));
    check("midrst:pix_valid", 128'(pix_valid), 128'(0));
    rst = 1'b0;
    gen_valid = 1'b0;
    check("midrst:no_pix", 128'(obs_q.size()), 128'(0));
    last_g = NR - 1;
    $display("job midrst id=%0d aborted by reset", g);

    rand_ops();
    for (int i = 0; i < NR; i++) rad[i] = 32'($urandom_range(50, 0));
    do_job(4'hF, 1'b0, 1'b0, 3, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
